ita_job_scheduler: RTL and testbench

Shares one ITA instance between NumReq requesters (cluster cores / DMA sequencers), each submitting a complete job descriptor (ctrl_t).
Round-robin arbitration picks one pending job at a time. The block drives the ITA controller's ctrl input with a registered, stable copy of the descriptor and pulses start for exactly one cycle.
It tracks the job by watching the controller's step, and returns a tagged completion, or an error on a start timeout, to the owner.
Sits between the register/HWPE front-end and ita_controller.

---
 rtl/ita_package.sv | 50 +++++
 rtl/ita_rr_arbiter.sv | 59 +++++
 rtl/ita_job_scheduler.sv | 133 +++++++++++++
 tb/tb_ita_job_scheduler.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/ita_package.sv
// ita_package: shared types for the ITA accelerator and its job scheduler.
//   layer_e / step_e / ctrl_t : controller descriptor and step encoding.
//   sched_state_e             : job scheduler FSM states.
//   ItaStartTimeout           : default start-timeout budget in cycles.
//   id_width()                : index width for a requester count (min 1).
package ita_package;

   typedef enum logic [1:0] {
      Attention,
      Linear,
      Feedforward
   } layer_e;

   typedef enum logic [2:0] {
      Idle,
      Q,
      K,
      V,
      QK,
      AV,
      OW,
      MatMul
   } step_e;

   typedef struct packed {
      logic        start;
      layer_e      layer;
      logic [7:0]  eps_mult;
      logic [7:0]  right_shift;
      logic [15:0] tile_e;
      logic [15:0] tile_f;
      logic [15:0] tile_s;
   } ctrl_t;

   // Prefixed so they do not collide with step_e::Idle.
   typedef enum logic [2:0] {
      SchedIdle,
      SchedLaunch,
      SchedWaitStart,
      SchedRun,
      SchedResp
   } sched_state_e;

   localparam int unsigned ItaStartTimeout = 16;

   function automatic int unsigned id_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/ita_rr_arbiter.sv
// ita_rr_arbiter: round-robin arbiter that owns its rotating pointer.
//   clk_i, rst_i  : clock, asynchronous active-high reset (pointer -> 0)
//   req_i         : request vector
//   advance_i     : a grant was accepted; move pointer past the winner
//   grant_o       : one-hot grant (all zero when nothing requests)
//   grant_idx_o   : index of the granted requester
module ita_rr_arbiter
   import ita_package::*;
#(
   parameter  int unsigned NumReq = 4,
   localparam int unsigned IdW    = id_width(NumReq)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [NumReq-1:0] req_i,
   input  logic              advance_i,
   output logic [NumReq-1:0] grant_o,
   output logic [IdW-1:0]    grant_idx_o
);

   logic [IdW-1:0] ptr_q, ptr_d;
   logic           found;
   int unsigned    win;
   int unsigned    idx;

   // Search upward from the pointer, wrapping; first requester wins.
   always_comb begin
      grant_o     = '0;
      grant_idx_o = '0;
      found       = 1'b0;
      win         = 0;
      idx         = 0;
      for (int unsigned k = 0; k < NumReq; k++) begin
         idx = 32'(ptr_q) + k;
         if (idx >= NumReq) idx = idx - NumReq;
         for (int unsigned i = 0; i < NumReq; i++) begin
            if (!found && (i == idx) && req_i[i]) begin
               found      = 1'b1;
               grant_o[i] = 1'b1;
               win        = i;
            end
         end
      end
      grant_idx_o = IdW'(win);
   end

   always_comb begin
      ptr_d = ptr_q;
      if (advance_i && found) begin
         ptr_d = (win == NumReq - 1) ? '0 : IdW'(win + 1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) ptr_q <= '0;
      else       ptr_q <= ptr_d;
   end

endmodule

// File: rtl/ita_job_scheduler.sv
// ita_job_scheduler: shares one ITA controller between NumReq requesters.
//   clk_i, rst_i   : clock, asynchronous active-high reset
//   req_valid_i    : per-requester job valid
//   req_ready_o    : per-requester accept (one-hot, only in idle)
//   req_ctrl_i     : per-requester descriptor (start field ignored)
//   ctrl_o         : registered descriptor to the controller, start pulsed once
//   step_i         : controller's current step
//   done_valid_o / done_ready_i / done_id_o / done_err_o : tagged completion
//   busy_o         : a job is in flight or its completion is pending
module ita_job_scheduler
   import ita_package::*;
#(
   parameter  int unsigned NumReq       = 4,
   parameter  int unsigned StartTimeout = ItaStartTimeout,
   localparam int unsigned IdW          = id_width(NumReq)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [NumReq-1:0] req_valid_i,
   output logic [NumReq-1:0] req_ready_o,
   input  ctrl_t             req_ctrl_i [NumReq],
   output ctrl_t             ctrl_o,
   input  step_e             step_i,
   output logic              done_valid_o,
   input  logic              done_ready_i,
   output logic [IdW-1:0]    done_id_o,
   output logic              done_err_o,
   output logic              busy_o
);

   localparam int unsigned CntW = (StartTimeout > 1) ? $clog2(StartTimeout) : 1;

   sched_state_e    state_q, state_d;
   ctrl_t           ctrl_q, ctrl_d;
   logic [IdW-1:0]  id_q, id_d;
   logic            err_q, err_d;
   logic [CntW-1:0] cnt_q, cnt_d;

   logic [NumReq-1:0] grant;
   logic [IdW-1:0]    grant_idx;
   logic              any_req;
   logic              accept;

   assign any_req = |req_valid_i;
   // Ready is asserted for the winner whenever anything is valid in idle,
   // so the handshake reduces to "idle and some request".
   assign accept  = (state_q == SchedIdle) && any_req;

   ita_rr_arbiter #(
      .NumReq (NumReq)
   ) i_arb (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .req_i       (req_valid_i),
      .advance_i   (accept),
      .grant_o     (grant),
      .grant_idx_o (grant_idx)
   );

   always_comb begin
      state_d     = state_q;
      ctrl_d      = ctrl_q;
      id_d        = id_q;
      err_d       = err_q;
      cnt_d       = cnt_q;
      req_ready_o = '0;
      case (state_q)
         SchedIdle: begin
            if (any_req) begin
               req_ready_o  = grant;
               ctrl_d       = req_ctrl_i[grant_idx];
               ctrl_d.start = 1'b0;
               id_d         = grant_idx;
               state_d      = SchedLaunch;
            end
         end
         SchedLaunch: begin
            // step_i still shows the pre-start value here; do not look at it.
            cnt_d   = '0;
            state_d = SchedWaitStart;
         end
         SchedWaitStart: begin
            // Launch plus StartTimeout-1 wait cycles gives a done exactly
            // StartTimeout cycles after the start pulse.
            if (step_i != Idle) begin
               state_d = SchedRun;
            end else if (cnt_q == CntW'(StartTimeout - 2)) begin
               err_d   = 1'b1;
               state_d = SchedResp;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         SchedRun: begin
            if (step_i == Idle) begin
               err_d   = 1'b0;
               state_d = SchedResp;
            end
         end
         SchedResp: begin
            if (done_ready_i) state_d = SchedIdle;
         end
         default: state_d = SchedIdle;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= SchedIdle;
         ctrl_q  <= '0;
         id_q    <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ctrl_q  <= ctrl_d;
         id_q    <= id_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      ctrl_o       = ctrl_q;
      ctrl_o.start = (state_q == SchedLaunch);
   end

   assign done_valid_o = (state_q == SchedResp);
   assign done_id_o    = done_valid_o ? id_q : '0;
   assign done_err_o   = done_valid_o & err_q;
   assign busy_o       = (state_q != SchedIdle);

endmodule

// File: tb/tb_ita_job_scheduler.sv
module tb_ita_job_scheduler;
   import ita_package::*;

   localparam int NR  = 4;
   localparam int TMO = 16;
   localparam int IW  = 2;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic [NR-1:0] req_valid_i;
   logic [NR-1:0] req_ready_o;
   ctrl_t         req_ctrl_i [NR];
   ctrl_t         ctrl_o;
   step_e         step_i;
   logic          done_valid_o;
   logic          done_ready_i;
   logic [IW-1:0] done_id_o;
   logic          done_err_o;
   logic          busy_o;

   int n_chk  = 0;
   int n_pass = 0;
   int ptr_m  = 0;   // model's round-robin pointer

   always #5 clk_i = ~clk_i;

   ita_job_scheduler #(
      .NumReq       (NR),
      .StartTimeout (TMO)
   ) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .req_valid_i  (req_valid_i),
      .req_ready_o  (req_ready_o),
      .req_ctrl_i   (req_ctrl_i),
      .ctrl_o       (ctrl_o),
      .step_i       (step_i),
      .done_valid_o (done_valid_o),
      .done_ready_i (done_ready_i),
      .done_id_o    (done_id_o),
      .done_err_o   (done_err_o),
      .busy_o       (busy_o)
   );

   task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
   endtask

   function automatic ctrl_t rand_ctrl();
      logic [95:0] r;
      r = {$urandom(), $urandom(), $urandom()};
      return ctrl_t'(r[$bits(ctrl_t)-1:0]);
   endfunction

   task automatic scramble();
      for (int i = 0; i < NR; i++) req_ctrl_i[i] = rand_ctrl();
   endtask

   // First valid requester at or after p, searching upward with wrap.
   function automatic int pick(input logic [NR-1:0] v, input int p);
      for (int k = 0; k < NR; k++) begin
         if (v[(p + k) % NR]) return (p + k) % NR;
      end
      return -1;
   endfunction

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle_cycle();
      req_valid_i  = '0;
      step_i       = Idle;
      done_ready_i = 1'b0;
      #1;
      check_val("idle_ready", 128'(req_ready_o), 128'(0));
      check_val("idle_busy", 128'(busy_o), 128'(0));
      check_val("idle_done_v", 128'(done_valid_o), 128'(0));
      tick();
   endtask

   // One whole job from the idle handshake cycle through the done handshake.
   // d: cycles after the start pulse at which step leaves Idle (>=TMO: never)
   // len: cycles step stays busy; bp: cycles of done backpressure.
   task automatic do_job(input logic [NR-1:0] vld, input int d, input int len,
                         input int bp, input bit hold, output int g);
      ctrl_t exp_c;
      ctrl_t launch_c;
      bit    tmo;
      int    c_done;
      g = pick(vld, ptr_m);
      req_valid_i  = vld;
      step_i       = Idle;
      done_ready_i = 1'b0;
      #1;
      check_val("hs_busy", 128'(busy_o), 128'(0));
      check_val("hs_done_v", 128'(done_valid_o), 128'(0));
      check_val("hs_ready", 128'(req_ready_o), 128'(NR'(1) << g));
      exp_c       = req_ctrl_i[g];
      exp_c.start = 1'b0;
      ptr_m       = (g + 1) % NR;
      tick();
      // launch cycle
      if (!hold) req_valid_i = NR'($urandom());
      scramble();
      #1;
      launch_c       = exp_c;
      launch_c.start = 1'b1;
      check_val("launch_ctrl", 128'(ctrl_o), 128'(launch_c));
      check_val("launch_busy", 128'(busy_o), 128'(1));
      check_val("launch_ready", 128'(req_ready_o), 128'(0));
      tick();
      tmo    = (d >= TMO);
      c_done = tmo ? TMO : d + len + 1;
      for (int c = 1; c < c_done; c++) begin
         step_i       = (!tmo && c >= d && c < d + len) ? MatMul : Idle;
         done_ready_i = 1'($urandom());
         if (!hold) req_valid_i = NR'($urandom());
         scramble();
         #1;
         check_val("run_ctrl", 128'(ctrl_o), 128'(exp_c));
         check_val("run_done_v", 128'(done_valid_o), 128'(0));
         check_val("run_busy", 128'(busy_o), 128'(1));
         check_val("run_ready", 128'(req_ready_o), 128'(0));
         tick();
      end
      step_i = Idle;
      for (int b = 0; b <= bp; b++) begin
         done_ready_i = (b == bp);
         #1;
         check_val("resp_done_v", 128'(done_valid_o), 128'(1));
         check_val("resp_id", 128'(done_id_o), 128'(g));
         check_val("resp_err", 128'(done_err_o), 128'(tmo));
         check_val("resp_ctrl", 128'(ctrl_o), 128'(exp_c));
         check_val("resp_ready", 128'(req_ready_o), 128'(0));
         tick();
      end
      done_ready_i = 1'b0;
      $display("job: req=%0d d=%0d len=%0d bp=%0d timeout=%0d", g, d, len, bp, tmo);
   endtask

   initial begin
      int g;
      int prev;
      logic [NR-1:0] v;
      rst_i        = 1'b1;
      req_valid_i  = '0;
      step_i       = Idle;
      done_ready_i = 1'b0;
      scramble();
      #2;
      check_val("rst_ctrl", 128'(ctrl_o), 128'(0));
      check_val("rst_busy", 128'(busy_o), 128'(0));
      check_val("rst_done_v", 128'(done_valid_o), 128'(0));
      check_val("rst_done_id", 128'(done_id_o), 128'(0));
      check_val("rst_done_err", 128'(done_err_o), 128'(0));
      check_val("rst_ready", 128'(req_ready_o), 128'(0));
      tick();
      rst_i = 1'b0;
      ptr_m = 0;

      // Fairness: everyone valid, expect 0,1,2,3,0.
      prev = -1;
      for (int k = 0; k < 5; k++) begin
         do_job('1, 1, 5, 0, 1'b1, g);
         check_val("fair_no_repeat", 128'(g != prev), 128'(1));
         prev = g;
      end

      // Single Linear job on req0, 40 busy cycles.
      scramble();
      req_ctrl_i[0].layer = Linear;
      do_job(4'b0001, 1, 40, 0, 1'b1, g);

      // Start timeout: controller never leaves Idle.
      do_job(4'b0100, TMO + 5, 1, 2, 1'b1, g);

      // Backpressure with req1 held pending, then req1 must win next.
      do_job(4'b0011, 2, 4, 10, 1'b1, g);
      do_job(4'b0010, 2, 3, 0, 1'b1, g);

      // Randomized traffic.
      for (int k = 0; k < 30; k++) begin
         if ($urandom_range(0, 3) == 0) idle_cycle();
         v = NR'($urandom_range(1, (1 << NR) - 1));
         do_job(v, $urandom_range(1, TMO + 2), $urandom_range(1, 8),
                $urandom_range(0, 3), 1'($urandom()), g);
      end

      // Asynchronous reset while in Run.
      v = 4'b0100;
      g = pick(v, ptr_m);
      req_valid_i = v;
      #1;
      check_val("ar_hs_ready", 128'(req_ready_o), 128'(NR'(1) << g));
      tick();
      req_valid_i = '0;
      tick();                 // launch
      step_i = MatMul;
      tick();                 // wait-start sees MatMul
      tick();                 // run
      rst_i = 1'b1;
      #1;
      check_val("ar_ctrl", 128'(ctrl_o), 128'(0));
      check_val("ar_busy", 128'(busy_o), 128'(0));
      check_val("ar_done_v", 128'(done_valid_o), 128'(0));
      check_val("ar_done_id", 128'(done_id_o), 128'(0));
      check_val("ar_done_err", 128'(done_err_o), 128'(0));
      check_val("ar_ready", 128'(req_ready_o), 128'(0));
      step_i = Idle;
      tick();
      rst_i = 1'b0;
      ptr_m = 0;
      $display("async reset applied in run");
      do_job(4'b1010, 2, 3, 0, 1'b1, g);
      do_job(4'b1111, 1, 2, 0, 1'b1, g);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
